alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 8-bit ALU between NUM_REQ requesters (pipeline EX stage, address unit, debug port, ...).
//  Round-robin arbitration with per-requester valid/ready handshake.
//  Drives the ALU's aluOp/srcA/srcB combinationally from the granted requester.
//  Registers the ALU result with the winner's ID into a single-entry response slot with valid/ready.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  DATA_W   8  operand/result width (matches ALU)
//  OP_W     4  ALU opcode width (matches ALU aluOp)
//  ID_W     $clog2(NUM_REQ)  requester index width (localparam)
// PORTS
//  clk          in   1                clock; all state updates on rising edge
//  rst          in   1                synchronous reset, active-high
//  req_valid    in   NUM_REQ          per-requester request valid
//  req_ready    out  NUM_REQ          per-requester accept (one-hot or zero)
//  req_op       in   NUM_REQ*OP_W     packed opcodes; requester i at [i*OP_W +: OP_W]
//  req_a        in   NUM_REQ*DATA_W   packed operand A
//  req_b        in   NUM_REQ*DATA_W   packed operand B
//  alu_op       out  OP_W             to ALU aluOp
//  alu_src_a    out  DATA_W           to ALU srcA
//  alu_src_b    out  DATA_W           to ALU srcB
//  alu_result   in   DATA_W           from ALU result (combinational)
//  rsp_valid    out  1                response slot holds a result
//  rsp_ready    in   1                consumer accepts response
//  rsp_id       out  ID_W             index of requester that produced rsp_data
//  rsp_data     out  DATA_W           registered ALU result
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0, state=IDLE; stats counters=0.
//  FSM (response slot):
//   IDLE : rsp_valid=0. Accept a grant -> FULL.
//   FULL : rsp_valid=1. rsp_ready=1 & new grant -> FULL (slot reloaded); rsp_ready=1 & no grant -> IDLE;
//          rsp_ready=0 -> FULL, slot held stable.
//  can_issue = (state==IDLE) | rsp_ready. Grant only when can_issue.
//  Arbitration: scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ; first req_valid[i] wins.
//   req_ready[winner]=1, all others 0. req_ready=0 everywhere when !can_issue or no valid.
//   req_ready is combinational from req_valid/state; a requester holds valid+operands until accepted.
//  On accept (cycle N): rr_ptr <= (winner+1) mod NUM_REQ; rsp_data<=alu_result; rsp_id<=winner.
//   rsp_valid=1 in cycle N+1 (latency 1). Throughput 1 op/cycle while rsp_ready=1.
//  ALU drive: granted -> req_op/a/b of winner. Otherwise alu_op=4'b0000 (nop) and alu_src_a/b=0.
//  rr_ptr does not change without a grant. Wrap: winner=NUM_REQ-1 -> rr_ptr=0.
//  Result width DATA_W; ALU overflow is truncated by the ALU, not checked here.
//  Reset mid-operation: pending response discarded; rsp_valid=0 next cycle; no req_ready during rst.
//  Opcode values are passed through unchecked (invalid ops produce ALU default result 0).
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: adds outputs stat_grants (NUM_REQ*16, per-requester grant count) and
//   stat_stalls (16, cycles with any req_valid but no grant). Both saturate at 16'hFFFF; cleared by rst.
//  ALU_ARB_STATS_EN undefined: these ports and counters do not exist; arbitration identical.
// TESTING
//  1 Single req: req_valid=4'b0010, op=1, a=8'h05, b=8'h03, rsp_ready=1 -> req_ready=4'b0010;
//    next cycle rsp_valid=1, rsp_id=1, rsp_data=8'h08.
//  2 Round-robin: req_valid=4'b1111 held, rsp_ready=1 after reset -> grants 0,1,2,3,0 on consecutive cycles.
//  3 Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with req_valid=4'b0001 -> req_ready=0,
//    rsp_data/rsp_id stable; rsp_ready=1 -> grant 0 same cycle, new result next cycle.
//  4 Idle drive: req_valid=0 -> alu_op=0, alu_src_a=0, alu_src_b=0; rsp_valid drops after pending consumed.
//  5 Wrap/overflow: req 3 op=1 a=8'hFF b=8'h02 -> rsp_data=8'h01, rsp_id=3, rr_ptr=0 next.
//  6 Reset mid-op: rst=1 while rsp_valid=1 -> next cycle rsp_valid=0, rr_ptr=0, first grant goes to req 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a registered response slot.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_src_a,
    output logic [DATA_W-1:0]         alu_src_b,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]         rsp_data
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants,
    output logic [15:0]               stat_stalls
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_nxt;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            can_issue;
    logic            grant;
    int              idx;

    // Rotating priority scan starting at rr_ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign can_issue = (state == IDLE) | rsp_ready;
    assign grant     = found & can_issue & ~rst;
    assign rsp_valid = (state == FULL);

    always_comb begin
        req_ready = '0;
        alu_op    = '0;
        alu_src_a = '0;
        alu_src_b = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            alu_op    = req_op[winner*OP_W +: OP_W];
            alu_src_a = req_a[winner*DATA_W +: DATA_W];
            alu_src_b = req_b[winner*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        if (winner == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = winner + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (rsp_ready) begin
                    state_nxt = grant ? FULL : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rr_ptr   <= rr_ptr_nxt;
                rsp_id   <= winner;
                rsp_data <= alu_result;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (grant && grant_cnt[winner] != 16'hFFFF) begin
                grant_cnt[winner] <= grant_cnt[winner] + 16'd1;
            end
            if (|req_valid && !grant && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt[i];
        end
    end

    assign stat_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic
// against a queue-based reference model and a small behavioural ALU.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*OW-1:0] req_op;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [OW-1:0]   alu_op;
    logic [DW-1:0]   alu_src_a;
    logic [DW-1:0]   alu_src_b;
    logic [DW-1:0]   alu_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            1:       return (a + b) & 255;
            2:       return (a - b) & 255;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            default: return 0;
        endcase
    endfunction

    always_comb alu_result = DW'(alu_ref(int'(alu_op), int'(alu_src_a), int'(alu_src_b)));

    typedef struct {
        int id;
        int data;
    } rsp_t;

    rsp_t sb[$];
    int   glog[$];
    bit   pend[N];
    int   m_op[N];
    int   m_a[N];
    int   m_b[N];
    int   m_ptr;
    bit   slot_full;
    int   last_ready;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic arm(input int i, input int op, input int a, input int b);
        pend[i] = 1'b1;
        m_op[i] = op;
        m_a[i]  = a;
        m_b[i]  = b;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_op[i*OW +: OW]    = OW'(m_op[i]);
            req_a[i*DW +: DW]     = DW'(m_a[i]);
            req_b[i*DW +: DW]     = DW'(m_b[i]);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model
    task automatic step();
        int w;
        bit can;
        drive();
        #2;
        w   = -1;
        can = !slot_full || rsp_ready;
        if (!rst && can) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && pend[j]) w = j;
            end
        end
        last_ready = int'(req_ready);
        chk("req_ready", int'(req_ready), (w >= 0) ? (1 << w) : 0);
        chk("alu_op", int'(alu_op), (w >= 0) ? m_op[w] : 0);
        chk("alu_src_a", int'(alu_src_a), (w >= 0) ? m_a[w] : 0);
        chk("alu_src_b", int'(alu_src_b), (w >= 0) ? m_b[w] : 0);
        if (rst) begin
            m_ptr     = 0;
            slot_full = 1'b0;
            sb.delete();
        end else begin
            if (w >= 0) begin
                sb.push_back('{w, alu_ref(m_op[w], m_a[w], m_b[w])});
                glog.push_back(w);
                pend[w] = 1'b0;
                m_ptr   = (w + 1) % N;
            end
            slot_full = (w >= 0) || (slot_full && !rsp_ready);
        end
        @(negedge clk);
    endtask

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("rsp_valid", int'(rsp_valid), int'(sb.size() != 0));
                if (rsp_valid && sb.size() != 0) begin
                    chk("rsp_id", int'(rsp_id), sb[0].id);
                    chk("rsp_data", int'(rsp_data), sb[0].data);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int exp_rr[5];
        int hold_id;
        int hold_data;
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            m_op[i] = 0;
            m_a[i]  = 0;
            m_b[i]  = 0;
        end
        m_ptr     = 0;
        slot_full = 1'b0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        drive();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("reset_valid", int'(rsp_valid), 0);
        chk("reset_id", int'(rsp_id), 0);
        chk("reset_data", int'(rsp_data), 0);

        // Single request from requester 1
        arm(1, 1, 8'h05, 8'h03);
        step();
        chk("single_grant", last_ready, 4'b0010);
        chk("single_valid", int'(rsp_valid), 1);
        chk("single_id", int'(rsp_id), 1);
        chk("single_data", int'(rsp_data), 8'h08);

        // Idle: response consumed, ALU driven to zero
        step();
        step();
        chk("idle_valid", int'(rsp_valid), 0);

        // Round-robin with all requesters asserted
        rst = 1'b1;
        step();
        rst = 1'b0;
        glog.delete();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) arm(i, 1 + (c + i) % 5, $urandom_range(255), $urandom_range(255));
            end
            step();
        end
        for (int k = 0; k < 5; k++) chk("rr_order", glog[k], exp_rr[k]);
        while (pend[0] || pend[1] || pend[2] || pend[3]) step();

        // Backpressure: slot held, no grants
        arm(0, 2, 8'h10, 8'h04);
        rsp_ready = 1'b0;
        hold_id   = int'(rsp_id);
        hold_data = int'(rsp_data);
        chk("bp_pre_valid", int'(rsp_valid), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_ready", last_ready, 0);
            chk("bp_id_stable", int'(rsp_id), hold_id);
            chk("bp_data_stable", int'(rsp_data), hold_data);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_grant", last_ready, 4'b0001);
        chk("bp_new_data", int'(rsp_data), 8'h0C);

        // Wrap and overflow from requester 3
        arm(3, 1, 8'hFF, 8'h02);
        step();
        chk("wrap_data", int'(rsp_data), 8'h01);
        chk("wrap_id", int'(rsp_id), 3);
        for (int i = 0; i < N; i++) arm(i, 3, 8'hF0, 8'h3C);
        step();
        chk("wrap_next", glog[$], 0);

        // Reset while a response is pending
        step();
        rsp_ready = 1'b0;
        chk("mid_pre_valid", int'(rsp_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk("mid_post_valid", int'(rsp_valid), 0);
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) arm(i, 4, 8'h0F, 8'h30);
        end
        step();
        chk("mid_first_grant", glog[$], 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1) == 1) begin
                    arm(i, $urandom_range(7), $urandom_range(255), $urandom_range(255));
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(99) == 0);
            step();
        end

        // Drain with a bounded cycle budget
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", int'(rsp_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
